// File: rtl/avalon_sram_responder.sv
// Avalon-MM pipelined SRAM bank: fixed read latency, bounded outstanding reads, power-on clear.
// Optional random waitrequest stalls when SRAM_RAND_STALL_EN is defined.
module avalon_sram_responder #(
    parameter int unsigned ADDR_W       = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    output logic        clear_busy,
    output logic        err_collision
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       clear_ptr_q, clear_ptr_d;
    logic [PEND_W-1:0]       pending_q, pending_d;
    logic                    err_q, err_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             rdata_q [READ_LATENCY];
    logic [31:0]             rdata_d [READ_LATENCY];
    logic [31:0]             mem_q   [DEPTH];

    logic [31:0]       offset;
    logic [29:0]       word_idx;
    logic              in_range;
    logic [ADDR_W-1:0] mem_idx;
    logic              unused_offset_lsb;

    logic              full;
    logic              stall;
    logic              wr_acc;
    logic              rd_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    // Below-base addresses wrap to a huge index and fall out of range.
    assign offset            = slave_address - BASE_ADDR;
    assign word_idx          = offset[31:2];
    assign in_range          = (word_idx >> ADDR_W) == '0;
    assign mem_idx           = word_idx[ADDR_W-1:0];
    assign unused_offset_lsb = ^offset[1:0];

`ifdef SRAM_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = lfsr_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign full = (pending_q == PEND_W'(MAX_PENDING));

    // A read paired with a write is dropped; the write still lands.
    always_comb begin
        slave_waitrequest = 1'b1;
        clear_busy        = 1'b1;
        wr_acc            = 1'b0;
        rd_acc            = 1'b0;
        mem_we            = 1'b0;
        mem_waddr         = clear_ptr_q;
        mem_wdata         = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
            end
            ST_READY: begin
                clear_busy        = 1'b0;
                slave_waitrequest = full | stall;
                wr_acc            = slave_write & ~slave_waitrequest;
                rd_acc            = slave_read & ~slave_write & ~slave_waitrequest;
                mem_we            = wr_acc & in_range;
                mem_waddr         = mem_idx;
                mem_wdata         = slave_writedata;
            end
            default: begin
                slave_waitrequest = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        vld_d[0]   = rd_acc;
        rdata_d[0] = (rd_acc && in_range) ? mem_q[mem_idx] : '0;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (rd_acc && !slave_readdatavalid) begin
            pending_d = pending_q + 1'b1;
        end else if (!rd_acc && slave_readdatavalid) begin
            pending_d = pending_q - 1'b1;
        end
    end

    assign err_d = err_q | (slave_read & wr_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign slave_readdatavalid = vld_q[READ_LATENCY-1];
    assign slave_readdata      = slave_readdatavalid ? rdata_q[READ_LATENCY-1] : '0;
    assign err_collision       = err_q;

endmodule

// File: tb/tb_avalon_sram_responder.sv
// Randomised bench for avalon_sram_responder: two configurations checked every cycle
// against a cycle-indexed response model (honours SRAM_RAND_STALL_EN when defined).
module tb_avalon_sram_responder;

    localparam int NC = 8192;
    localparam logic [31:0] BASE0 = 32'h0000_1000;
    localparam logic [31:0] BASE1 = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr    [2];
    logic        rd      [2];
    logic        wr      [2];
    logic [31:0] wdata   [2];
    logic        waitreq [2];
    logic [31:0] rdata   [2];
    logic        rvalid  [2];
    logic        cbusy   [2];
    logic        cerr    [2];

    always #5 clk = ~clk;

    avalon_sram_responder #(
        .ADDR_W(8), .BASE_ADDR(BASE0), .READ_LATENCY(2), .MAX_PENDING(4)
    ) dut0 (
        .clk(clk), .rst(rst),
        .slave_address(addr[0]), .slave_read(rd[0]), .slave_write(wr[0]),
        .slave_writedata(wdata[0]), .slave_waitrequest(waitreq[0]),
        .slave_readdata(rdata[0]), .slave_readdatavalid(rvalid[0]),
        .clear_busy(cbusy[0]), .err_collision(cerr[0])
    );

    avalon_sram_responder #(
        .ADDR_W(8), .BASE_ADDR(BASE1), .READ_LATENCY(4), .MAX_PENDING(2)
    ) dut1 (
        .clk(clk), .rst(rst),
        .slave_address(addr[1]), .slave_read(rd[1]), .slave_write(wr[1]),
        .slave_writedata(wdata[1]), .slave_waitrequest(waitreq[1]),
        .slave_readdata(rdata[1]), .slave_readdatavalid(rvalid[1]),
        .clear_busy(cbusy[1]), .err_collision(cerr[1])
    );

    // Reference model: expected response per DUT per cycle, plus a word array per bank.
    bit          exp_v [2][NC];
    logic [31:0] exp_d [2][NC];
    logic [31:0] mem_m [2][256];
    bit          err_m [2];
    int          ready_cyc [2];
    bit          in_rst;
    bit          acc_last [2];
    bit          busy_last [2];
    int          cyc;
    int          errors;
    int          checks;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int mp_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? BASE0 : BASE1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic eval_dut(input int k);
        int          lat;
        int          pend;
        bit          busy;
        bit          ewait;
        bit          acc;
        logic [31:0] off;
        int unsigned idx;
        bit          inr;
        lat  = lat_of(k);
        pend = 0;
        for (int i = 0; i < lat; i++) begin
            if (exp_v[k][cyc+i]) pend++;
        end
        busy  = in_rst || (cyc < ready_cyc[k]);
        ewait = busy || (pend == mp_of(k));

        check($sformatf("dut%0d.readdatavalid", k), 32'(rvalid[k]), 32'(exp_v[k][cyc]));
        check($sformatf("dut%0d.readdata", k), rdata[k], exp_v[k][cyc] ? exp_d[k][cyc] : 32'h0);
        check($sformatf("dut%0d.clear_busy", k), 32'(cbusy[k]), 32'(busy));
        check($sformatf("dut%0d.err_collision", k), 32'(cerr[k]), 32'(err_m[k]));
`ifdef SRAM_RAND_STALL_EN
        if (ewait) check($sformatf("dut%0d.waitrequest", k), 32'(waitreq[k]), 32'd1);
        acc = !ewait && !waitreq[k];
`else
        check($sformatf("dut%0d.waitrequest", k), 32'(waitreq[k]), 32'(ewait));
        acc = !ewait;
`endif
        busy_last[k] = cbusy[k];
        acc_last[k]  = acc && (rd[k] || wr[k]);

        if (acc_last[k]) begin
            off = addr[k] - base_of(k);
            idx = off >> 2;
            inr = idx < 256;
            if (wr[k]) begin
                if (inr) mem_m[k][idx] = wdata[k];
                if (rd[k]) err_m[k] = 1'b1;
            end else begin
                exp_v[k][cyc+lat] = 1'b1;
                exp_d[k][cyc+lat] = inr ? mem_m[k][idx] : 32'h0;
            end
        end
    endtask

    task automatic cycle();
        if (cyc >= NC - 8) begin
            errors++;
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC - 8);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        @(negedge clk);
        eval_dut(0);
        eval_dut(1);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Holds the command while waitrequest is up; reports cycles spent waiting.
    task automatic do_cmd(input int k, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int waited);
        rd[k]    = r;
        wr[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        waited   = 0;
        cycle();
        while (!acc_last[k] && waited < 40) begin
            waited++;
            cycle();
        end
        check($sformatf("dut%0d.accepted", k), 32'(acc_last[k]), 32'd1);
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst    = 1'b1;
        in_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k]    = 1'b0;
            wr[k]    = 1'b0;
            err_m[k] = 1'b0;
            for (int i = 0; i < 256; i++) mem_m[k][i] = 32'h0;
            for (int c = cyc; c < NC; c++) exp_v[k][c] = 1'b0;
        end
        idle(n);
        rst          = 1'b0;
        in_rst       = 1'b0;
        ready_cyc[0] = cyc + 256;
        ready_cyc[1] = cyc + 256;
    endtask

    task automatic count_clear();
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (busy_last[0]) n++;
            else break;
        end
        check("clear_cycles", 32'(n), 32'd256);
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return base_of(k) - 4 * $urandom_range(1, 8);
        if (sel == 1) return base_of(k) + 4 * (256 + $urandom_range(0, 63));
        return base_of(k) + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
    endfunction

    task automatic random_phase(input int n, input int rd_pct);
        int k;
        int w;
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, 1));
            if (int'($urandom_range(0, 99)) < rd_pct)
                do_cmd(k, 1'b1, 1'b0, rand_addr(k), 32'h0, w);
            else
                do_cmd(k, 1'b0, 1'b1, rand_addr(k), $urandom, w);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    int w0, w1, w2, stalls;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        for (int k = 0; k < 2; k++) begin
            addr[k]      = 32'h0;
            wdata[k]     = 32'h0;
            rd[k]        = 1'b0;
            wr[k]        = 1'b0;
            ready_cyc[k] = 0;
        end
        apply_reset(3);
        count_clear();

        // freshly cleared word reads back zero
        for (int k = 0; k < 2; k++) do_cmd(k, 1'b1, 1'b0, base_of(k) + 32'd20, 32'h0, w0);
        idle(6);

        // write then read the very next cycle
        for (int k = 0; k < 2; k++) begin
            do_cmd(k, 1'b0, 1'b1, base_of(k) + 32'h14, 32'h0001_8000, w0);
            do_cmd(k, 1'b1, 1'b0, base_of(k) + 32'h14, 32'h0, w0);
            idle(6);
        end

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) do_cmd(k, 1'b0, 1'b1, base_of(k) + 4 * i, $urandom, w0);

        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            do_cmd(0, 1'b1, 1'b0, BASE0 + 4 * i, 32'h0, w0);
            stalls += w0;
        end
`ifndef SRAM_RAND_STALL_EN
        check("stream_stall_cycles", 32'(stalls), 32'd0);
`endif
        idle(6);

        // pending limit on the deep-latency bank: third read waits for the first valid
        do_cmd(1, 1'b1, 1'b0, BASE1 + 32'd4, 32'h0, w0);
        do_cmd(1, 1'b1, 1'b0, BASE1 + 32'd8, 32'h0, w1);
        do_cmd(1, 1'b1, 1'b0, BASE1 + 32'd12, 32'h0, w2);
`ifndef SRAM_RAND_STALL_EN
        check("limit_third_wait", 32'(w2), 32'd3);
`endif
        idle(8);

        do_cmd(0, 1'b1, 1'b1, BASE0 + 32'd12, 32'hFFFF_0000, w0);
        do_cmd(0, 1'b1, 1'b0, BASE0 + 32'd12, 32'h0, w0);
        do_cmd(0, 1'b1, 1'b0, BASE0 - 32'd4, 32'h0, w0);
        idle(6);

        random_phase(300, 50);
        idle(8);

        // reset with two reads in flight
        do_cmd(0, 1'b1, 1'b0, BASE0 + 32'd12, 32'h0, w0);
        do_cmd(0, 1'b1, 1'b0, BASE0 + 32'd20, 32'h0, w0);
        apply_reset(2);
        count_clear();
        do_cmd(0, 1'b1, 1'b0, BASE0 + 32'd12, 32'h0, w0);
        idle(4);

        random_phase(40, 0);
        random_phase(100, 100);
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
